ram_ctl: RTL and testbench
==========================

# ram_ctl

Sequencer that sits directly upstream of the external SRAM, or `mock_ram` in simulation. It accepts single-byte read and write requests from two requesters and arbitrates between them round-robin. Port A is the CPU/video side; port B is the MCU bridge. For each accepted request it drives the SRAM address, data and active-low strobes with guaranteed setup and hold cycles, captures read data, and reports completion with a one-cycle `done` pulse.

## Interface
Parameters:
- ADDR_WIDTH, default RAM_ADDR_WIDTH: SRAM address width.
- DATA_WIDTH, default DATA_WIDTH (8): data width.
- STROBE_CYCLES, default 2: cycles the `we_n`/`oe_n` strobe is held low. Legal range is 1..15; other values are an elaboration error.

Ports:
- clock_i  in  1  system clock; all logic is on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- a_valid_i  in  1  port A request valid.
- a_ready_o  out  1  port A request accepted this cycle.
- a_we_i  in  1  port A: 1 = write, 0 = read.
- a_addr_i  in  ADDR_WIDTH  port A address.
- a_wr_data_i  in  DATA_WIDTH  port A write data.
- a_rd_data_o  out  DATA_WIDTH  port A last read data.
- a_done_o  out  1  port A completion pulse.
- b_valid_i, b_ready_o, b_we_i, b_addr_i, b_wr_data_i, b_rd_data_o, b_done_o: same as port A, for port B.
- ram_addr_o  out  ADDR_WIDTH  SRAM address.
- ram_data_o  out  DATA_WIDTH  SRAM write data.
- ram_data_i  in  DATA_WIDTH  SRAM read data.
- ram_data_oe_o  out  1  drive enable for the external data bus.
- ram_we_n_o  out  1  SRAM write strobe, active low.
- ram_oe_n_o  out  1  SRAM output enable, active low.

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - The block selects one port with `valid` high.
  - `x_ready_o` is combinational and high only for the selected port, and only while in IDLE.
  - A handshake completes on a rising edge with `valid & ready` both high.
  - On the handshake the block latches `we`, `addr` and `wr_data` into internal registers and moves to SETUP. The requester may change its inputs after the handshake.
- Arbitration:
  - If only one port is valid, that port is granted.
  - If both are valid, the port not granted last is granted.
  - `last_grant` resets to B, so A wins the first tie.
  - A port held continuously valid can never starve the other.
- SETUP (1 cycle):
  - `ram_addr_o` and `ram_data_o` come from the latched registers.
  - Both strobes are high.
  - `ram_data_oe_o` = latched `we`.
- STROBE (STROBE_CYCLES cycles, counted by a down-counter):
  - Write: `ram_we_n_o` = 0 and `ram_data_oe_o` = 1.
  - Read: `ram_oe_n_o` = 0 and `ram_data_oe_o` = 0.
- HOLD (1 cycle):
  - Both strobes are high; address and write data remain stable.
  - On a read, `ram_data_i` is captured into the granted port's `rd_data` register at the rising edge that ends HOLD.
  - The next state is IDLE.
- Completion: the granted port's `done_o` is a registered pulse, high for exactly the one cycle following HOLD.
  - That cycle is IDLE, so a new request may be accepted in it.
- `rd_data_o` holds its value until the next read completes on the same port. Writes do not change it.
- All `ram_*` outputs and `done`/`rd_data` are registered, so there are no glitches.
- Invariants:
  - `ram_we_n_o` and `ram_oe_n_o` are never low together.
  - `ram_data_oe_o` is never 1 while `ram_oe_n_o` = 0.
  - `ram_addr_o` never changes while either strobe is low.
- Reset (asserted at any time, including mid-STROBE):
  - State returns to IDLE immediately.
  - `ram_we_n_o` = `ram_oe_n_o` = 1, `ram_data_oe_o` = 0.
  - `ram_addr_o` = 0, `ram_data_o` = 0.
  - Both `rd_data_o` = 0, both `done_o` = 0, both `ready_o` = 0 while in reset.
  - `last_grant` = B.
  - The aborted transaction produces no `done` pulse.

## Timing
- Handshake at edge 0. SETUP occupies cycle 1, STROBE occupies cycles 2..1+S, HOLD occupies cycle 2+S, and `done` is high in cycle 3+S (S = STROBE_CYCLES).
- With the default S = 2: strobe low for cycles 2–3, HOLD in cycle 4, `done` in cycle 5.
- Throughput: one transaction per S+3 cycles, back to back.
- `mock_ram` (registered read on the rising edge while `oe_n` is low) returns valid data by the end of the first STROBE cycle. Capture at the end of HOLD is therefore valid for any S ≥ 1.

## Test plan
- Port A writes 0xA5 to 0x1234 (S=2): `a_ready_o` is high at edge 0; `ram_we_n_o` is low in exactly cycles 2–3 with `ram_addr_o` = 0x1234 and `ram_data_o` = 0xA5; `a_done_o` is high only in cycle 5; `mock_ram` holds 0xA5 at 0x1234.
- Port B reads 0x1234 after the write: `ram_oe_n_o` is low for 2 cycles with `ram_data_oe_o` = 0; `b_rd_data_o` = 0xA5 in the `b_done_o` cycle; `a_rd_data_o` is unchanged.
- Both ports valid continuously from reset release, with distinct addresses: grants alternate A, B, A, B; each `done` comes 5 cycles after its grant; no two transactions overlap.
- Reset asserted in the first STROBE cycle of a write of 0x3C to 0x0100: `ram_we_n_o` returns to 1 asynchronously; no `done` pulse; all outputs read back their reset values; the first request after reset completes normally.
- Run with S=1 and S=15: the strobe width equals S exactly; a write followed by a readback of 0x5A at the maximum address 2^ADDR_WIDTH−1 returns 0x5A.
- Every test: an assertion checks that `we_n`/`oe_n` are never both low, that `data_oe` is never 1 while `oe_n` = 0, and that the address is stable while any strobe is low.

Source files
------------

// File: rtl/ram_ctl.sv
// ram_ctl: two-port round-robin request sequencer for an asynchronous SRAM.
// Each accepted byte access runs SETUP, STROBE (STROBE_CYCLES), HOLD, then a done pulse.
module ram_ctl #(
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_wr_data_i,
    output logic [DATA_WIDTH-1:0] a_rd_data_o,
    output logic                  a_done_o,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_wr_data_i,
    output logic [DATA_WIDTH-1:0] b_rd_data_o,
    output logic                  b_done_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  ram_data_oe_o,
    output logic                  ram_we_n_o,
    output logic                  ram_oe_n_o
);

    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
        $error("ram_ctl: STROBE_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    last_b_q, last_b_d;
    logic                    grant_b_q, grant_b_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    we_n_q, we_n_d;
    logic                    oe_n_q, oe_n_d;
    logic                    doe_q, doe_d;
    logic                    a_done_q, a_done_d;
    logic                    b_done_q, b_done_d;
    logic [DATA_WIDTH-1:0]   a_rd_q, a_rd_d;
    logic [DATA_WIDTH-1:0]   b_rd_q, b_rd_d;
    logic                    sel_b;
    logic                    hs;

    // B wins only when A is idle or A was the previous grant.
    assign sel_b     = b_valid_i && (!a_valid_i || !last_b_q);
    assign hs        = (state_q == IDLE) && (a_valid_i || b_valid_i);
    assign a_ready_o = reset_n_i && (state_q == IDLE) && a_valid_i && !sel_b;
    assign b_ready_o = reset_n_i && (state_q == IDLE) && sel_b;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_b_q  <= 1'b1;
            grant_b_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            doe_q     <= 1'b0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            a_rd_q    <= '0;
            b_rd_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_b_q  <= last_b_d;
            grant_b_q <= grant_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            doe_q     <= doe_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            a_rd_q    <= a_rd_d;
            b_rd_q    <= b_rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:   if (hs) state_d = SETUP;
            SETUP: begin
                state_d = STROBE;
                cnt_d   = 4'(STROBE_CYCLES - 1);
            end
            STROBE: begin
                if (cnt_q == '0) state_d = HOLD;
                else             cnt_d   = cnt_q - 4'd1;
            end
            HOLD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobe/bus registers are computed from the next state so the pins change on the phase edge.
    always_comb begin
        last_b_d  = last_b_q;
        grant_b_d = grant_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rd_d    = a_rd_q;
        b_rd_d    = b_rd_q;
        if (hs) begin
            last_b_d  = sel_b;
            grant_b_d = sel_b;
            we_d      = sel_b ? b_we_i      : a_we_i;
            addr_d    = sel_b ? b_addr_i    : a_addr_i;
            wdata_d   = sel_b ? b_wr_data_i : a_wr_data_i;
        end
        we_n_d   = !((state_d == STROBE) && we_d);
        oe_n_d   = !((state_d == STROBE) && !we_d);
        doe_d    = (state_d != IDLE) && we_d;
        a_done_d = (state_q == HOLD) && !grant_b_q;
        b_done_d = (state_q == HOLD) && grant_b_q;
        if ((state_q == HOLD) && !we_q) begin
            if (grant_b_q) b_rd_d = ram_data_i;
            else           a_rd_d = ram_data_i;
        end
    end

    assign ram_addr_o    = addr_q;
    assign ram_data_o    = wdata_q;
    assign ram_data_oe_o = doe_q;
    assign ram_we_n_o    = we_n_q;
    assign ram_oe_n_o    = oe_n_q;
    assign a_done_o      = a_done_q;
    assign b_done_o      = b_done_q;
    assign a_rd_data_o   = a_rd_q;
    assign b_rd_data_o   = b_rd_q;

endmodule

// File: tb/tb_ram_ctl.sv
// tb_ram_ctl: directed table-driven bench for ram_ctl with behavioural SRAMs,
// covering S=2 transactions, arbitration, mid-strobe reset, and S=1 / S=15 widths.
module tb_ram_ctl;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int S  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main instance (S=2)
    logic a_valid, a_we, a_ready, a_done, b_valid, b_we, b_ready, b_done;
    logic [AW-1:0] a_addr, b_addr, m_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rd, b_rd, m_wd, m_rdq;
    logic m_doe, m_we_n, m_oe_n;
    logic [DW-1:0] mem_m [0:65535];

    // S=1 and S=15 instances share their port-A stimulus
    logic x_valid, x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;
    logic p1_ready, p1_done, p1_bready, p1_bdone, p1_doe, p1_we_n, p1_oe_n;
    logic p15_ready, p15_done, p15_bready, p15_bdone, p15_doe, p15_we_n, p15_oe_n;
    logic [AW-1:0] p1_addr, p15_addr;
    logic [DW-1:0] p1_rd, p1_brd, p1_wd, p1_rdq, p15_rd, p15_brd, p15_wd, p15_rdq;
    logic [DW-1:0] mem_1 [0:65535];
    logic [DW-1:0] mem_15 [0:65535];

    int nvec = 0;
    int nerr = 0;
    int inv_err = 0;
    logic [DW-1:0] ra_m, rb_m;

    ram_ctl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_CYCLES(S)) u_dut (
        .clock_i(clk), .reset_n_i(rst_n),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_we_i(a_we), .a_addr_i(a_addr),
        .a_wr_data_i(a_wdata), .a_rd_data_o(a_rd), .a_done_o(a_done),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_we_i(b_we), .b_addr_i(b_addr),
        .b_wr_data_i(b_wdata), .b_rd_data_o(b_rd), .b_done_o(b_done),
        .ram_addr_o(m_addr), .ram_data_o(m_wd), .ram_data_i(m_rdq),
        .ram_data_oe_o(m_doe), .ram_we_n_o(m_we_n), .ram_oe_n_o(m_oe_n));

    ram_ctl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_CYCLES(1)) u_s1 (
        .clock_i(clk), .reset_n_i(rst_n),
        .a_valid_i(x_valid), .a_ready_o(p1_ready), .a_we_i(x_we), .a_addr_i(x_addr),
        .a_wr_data_i(x_wdata), .a_rd_data_o(p1_rd), .a_done_o(p1_done),
        .b_valid_i(1'b0), .b_ready_o(p1_bready), .b_we_i(1'b0), .b_addr_i('0),
        .b_wr_data_i('0), .b_rd_data_o(p1_brd), .b_done_o(p1_bdone),
        .ram_addr_o(p1_addr), .ram_data_o(p1_wd), .ram_data_i(p1_rdq),
        .ram_data_oe_o(p1_doe), .ram_we_n_o(p1_we_n), .ram_oe_n_o(p1_oe_n));

    ram_ctl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_CYCLES(15)) u_s15 (
        .clock_i(clk), .reset_n_i(rst_n),
        .a_valid_i(x_valid), .a_ready_o(p15_ready), .a_we_i(x_we), .a_addr_i(x_addr),
        .a_wr_data_i(x_wdata), .a_rd_data_o(p15_rd), .a_done_o(p15_done),
        .b_valid_i(1'b0), .b_ready_o(p15_bready), .b_we_i(1'b0), .b_addr_i('0),
        .b_wr_data_i('0), .b_rd_data_o(p15_brd), .b_done_o(p15_bdone),
        .ram_addr_o(p15_addr), .ram_data_o(p15_wd), .ram_data_i(p15_rdq),
        .ram_data_oe_o(p15_doe), .ram_we_n_o(p15_we_n), .ram_oe_n_o(p15_oe_n));

    // Behavioural SRAMs: write while we_n low, registered read while oe_n low.
    always @(posedge clk) begin
        if (!m_we_n)   mem_m[m_addr]    <= m_wd;
        if (!m_oe_n)   m_rdq            <= mem_m[m_addr];
        if (!p1_we_n)  mem_1[p1_addr]   <= p1_wd;
        if (!p1_oe_n)  p1_rdq           <= mem_1[p1_addr];
        if (!p15_we_n) mem_15[p15_addr] <= p15_wd;
        if (!p15_oe_n) p15_rdq          <= mem_15[p15_addr];
    end

    // Bus invariants on every instance.
    logic pl_m = 1'b0, pl_1 = 1'b0, pl_15 = 1'b0;
    logic [AW-1:0] pa_m, pa_1, pa_15;
    function automatic bit inv_bad(logic we_n, logic oe_n, logic doe, logic pl,
                                   logic [AW-1:0] pa, logic [AW-1:0] addr);
        return (!we_n && !oe_n) || (doe && !oe_n) || (pl && (!we_n || !oe_n) && addr !== pa);
    endfunction
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (inv_bad(m_we_n, m_oe_n, m_doe, pl_m, pa_m, m_addr)) begin
                inv_err++;
                $display("FAIL invariant_main: we_n=%b oe_n=%b oe=%b addr=%h required stable %h", m_we_n, m_oe_n, m_doe, m_addr, pa_m);
            end
            if (inv_bad(p1_we_n, p1_oe_n, p1_doe, pl_1, pa_1, p1_addr)) begin
                inv_err++;
                $display("FAIL invariant_s1: we_n=%b oe_n=%b oe=%b addr=%h", p1_we_n, p1_oe_n, p1_doe, p1_addr);
            end
            if (inv_bad(p15_we_n, p15_oe_n, p15_doe, pl_15, pa_15, p15_addr)) begin
                inv_err++;
                $display("FAIL invariant_s15: we_n=%b oe_n=%b oe=%b addr=%h", p15_we_n, p15_oe_n, p15_doe, p15_addr);
            end
        end
        pl_m  <= rst_n && (!m_we_n || !m_oe_n);
        pl_1  <= rst_n && (!p1_we_n || !p1_oe_n);
        pl_15 <= rst_n && (!p15_we_n || !p15_oe_n);
        pa_m  <= m_addr;
        pa_1  <= p1_addr;
        pa_15 <= p15_addr;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic reset_checks();
        chk("rst_we_n", 32'(m_we_n), 1);
        chk("rst_oe_n", 32'(m_oe_n), 1);
        chk("rst_data_oe", 32'(m_doe), 0);
        chk("rst_addr", 32'(m_addr), 0);
        chk("rst_wdata", 32'(m_wd), 0);
        chk("rst_a_rd", 32'(a_rd), 0);
        chk("rst_b_rd", 32'(b_rd), 0);
        chk("rst_a_done", 32'(a_done), 0);
        chk("rst_b_done", 32'(b_done), 0);
        chk("rst_a_ready", 32'(a_ready), 0);
        chk("rst_b_ready", 32'(b_ready), 0);
    endtask

    // One full transaction on the S=2 instance, starting at a negedge with the DUT idle.
    task automatic txn(input bit pb, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        int unsigned smask, dmask, odmask;
        bit got, addr_ok, bus_ok;
        logic [DW-1:0] rdv;
        a_we = we; b_we = we; a_addr = addr; b_addr = addr; a_wdata = wd; b_wdata = wd;
        a_valid = !pb; b_valid = pb;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (pb ? b_ready : a_ready) begin got = 1; break; end
            @(negedge clk);
        end
        chk("txn_ready", 32'(got), 1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 0; b_valid = 0;
        a_addr = ~addr; b_addr = ~addr; a_wdata = ~wd; b_wdata = ~wd;
        if (!we) begin
            if (pb) rb_m = rd; else ra_m = rd;
        end
        smask = 0; dmask = 0; odmask = 0; addr_ok = 1; bus_ok = 1; rdv = 'x;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            if (we ? !m_we_n : !m_oe_n) begin
                smask |= 32'd1 << c;
                if (m_addr !== addr) addr_ok = 0;
                if (m_doe !== we || (we && m_wd !== wd)) bus_ok = 0;
            end
            if (we ? !m_oe_n : !m_we_n) bus_ok = 0;
            if (pb ? b_done : a_done) dmask |= 32'd1 << c;
            if (pb ? a_done : b_done) odmask |= 32'd1 << c;
            if (c == S + 3) rdv = pb ? b_rd : a_rd;
        end
        chk("txn_strobe_cycles", smask, ((32'd1 << S) - 1) << 2);
        chk("txn_done_cycle", dmask, 32'd1 << (S + 3));
        chk("txn_other_done", odmask, 0);
        chk("txn_addr", 32'(addr_ok), 1);
        chk("txn_bus", 32'(bus_ok), 1);
        chk("txn_rd_at_done", 32'(rdv), 32'(pb ? rb_m : ra_m));
        chk("txn_other_rd", 32'(pb ? a_rd : b_rd), 32'(pb ? ra_m : rb_m));
    endtask

    // Same transaction to the max address on the S=1 and S=15 instances together.
    task automatic xtxn(input bit we);
        int w1, w15, d1, d15;
        bit got;
        x_we = we; x_addr = '1; x_wdata = 8'h5A; x_valid = 1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (p1_ready && p15_ready) begin got = 1; break; end
            @(negedge clk);
        end
        chk("x_ready", 32'(got), 1);
        @(posedge clk);
        @(negedge clk);
        x_valid = 0;
        w1 = 0; w15 = 0; d1 = 0; d15 = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (we ? !p1_we_n : !p1_oe_n) w1++;
            if (we ? !p15_we_n : !p15_oe_n) w15++;
            if (p1_done && d1 == 0) d1 = c;
            if (p15_done && d15 == 0) d15 = c;
        end
        chk("s1_strobe_width", 32'(w1), 1);
        chk("s15_strobe_width", 32'(w15), 15);
        chk("s1_done_cycle", 32'(d1), 4);
        chk("s15_done_cycle", 32'(d15), 18);
    endtask

    typedef struct {
        bit pb;
        bit we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [8];
        int ng, nd, nres;
        bit gp [4];
        bit dp [4];
        int gc [4];
        int dc [4];
        bit got;

        vecs[0] = '{0, 1, 16'h1234, 8'hA5, 8'h00};
        vecs[1] = '{1, 0, 16'h1234, 8'h00, 8'hA5};
        vecs[2] = '{0, 0, 16'h1234, 8'h00, 8'hA5};
        vecs[3] = '{1, 1, 16'h0042, 8'h3C, 8'h00};
        vecs[4] = '{0, 0, 16'h0042, 8'h00, 8'h3C};
        vecs[5] = '{0, 1, 16'h1234, 8'hFF, 8'h00};
        vecs[6] = '{1, 0, 16'h1234, 8'h00, 8'hFF};
        vecs[7] = '{1, 0, 16'h0042, 8'h00, 8'h3C};

        rst_n = 0;
        a_valid = 0; b_valid = 0; a_we = 0; b_we = 0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        x_valid = 0; x_we = 0; x_addr = '0; x_wdata = '0;
        ra_m = '0; rb_m = '0;
        repeat (2) @(negedge clk);
        a_valid = 1; b_valid = 1;
        #1;
        reset_checks();
        a_valid = 0; b_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].pb, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rd);
            if (i == 0) chk("mem_after_write", 32'(mem_m[16'h1234]), 32'h A5);
        end

        // Both ports valid from reset release: grants must alternate A, B, A, B.
        @(negedge clk);
        rst_n = 0;
        ra_m = '0; rb_m = '0;
        a_we = 1; a_addr = 16'h0010; a_wdata = 8'h11; a_valid = 1;
        b_we = 1; b_addr = 16'h0020; b_wdata = 8'h22; b_valid = 1;
        @(negedge clk);
        rst_n = 1;
        ng = 0; nd = 0;
        for (int cyc = 0; cyc < 60 && nd < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (ng == 4) begin a_valid = 0; b_valid = 0; end
            #1;
            if (ng < 4 && (a_ready || b_ready)) begin
                gp[ng] = b_ready; gc[ng] = cyc; ng++;
            end
            if (nd < 4 && (a_done || b_done)) begin
                dp[nd] = b_done; dc[nd] = cyc; nd++;
            end
        end
        a_valid = 0; b_valid = 0;
        chk("arb_done_count", 32'(nd), 4);
        for (int k = 0; k < 4; k++) begin
            chk("arb_grant_port", 32'(gp[k]), 32'(k % 2));
            chk("arb_done_port", 32'(dp[k]), 32'(k % 2));
            chk("arb_done_latency", 32'(dc[k] - gc[k]), 5);
            if (k > 0) chk("arb_no_overlap", 32'(gc[k]), 32'(dc[k-1]));
        end
        chk("arb_mem_a", 32'(mem_m[16'h0010]), 32'h11);
        chk("arb_mem_b", 32'(mem_m[16'h0020]), 32'h22);

        // Reset in the first STROBE cycle of a write.
        @(negedge clk);
        a_we = 1; a_addr = 16'h0100; a_wdata = 8'h3C; a_valid = 1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (a_ready) begin got = 1; break; end
            @(negedge clk);
        end
        chk("abort_ready", 32'(got), 1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 0;
        @(negedge clk);
        chk("abort_strobe_low", 32'(m_we_n), 0);
        rst_n = 0;
        a_valid = 1; b_valid = 1;
        #1;
        reset_checks();
        nres = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_done || b_done) nres++;
        end
        a_valid = 0; b_valid = 0;
        rst_n = 1;
        ra_m = '0; rb_m = '0;
        repeat (6) begin
            @(negedge clk);
            if (a_done || b_done) nres++;
        end
        chk("abort_no_done", 32'(nres), 0);
        txn(0, 1, 16'h0100, 8'h3C, 8'h00);
        txn(1, 0, 16'h0100, 8'h00, 8'h3C);

        // Strobe width and max-address readback at S=1 and S=15.
        @(negedge clk);
        xtxn(1);
        xtxn(0);
        chk("s1_readback", 32'(p1_rd), 32'h5A);
        chk("s15_readback", 32'(p15_rd), 32'h5A);

        chk("invariants", 32'(inv_err), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
